// File: rtl/ib_replay_buffer.sv
// ib_replay_buffer: two-entry holding FIFO for instructions deferred by the
// dual-issue hazard selector. Held packets are patched with writeback results
// so their source operands stay current until they are re-issued.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 6
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 16
`endif
`ifndef JUMP_WIDTH
`define JUMP_WIDTH 26
`endif
`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module ib_replay_buffer #(
  parameter int PKT_W = `PC_WIDTH + `OPCODE_WIDTH + `FUNCT_WIDTH + `IMM_WIDTH +
                        `JUMP_WIDTH + 3*`AWIDTH + 2*`DWIDTH + 7
) (
  input  logic               ib_clk,
  input  logic               ib_rst,
  input  logic               ib_i_we,
  input  logic [PKT_W-1:0]   ib_i_pkt,
  input  logic               ib_i_ready,
  input  logic               ib_i_flush,
  input  logic               ib_i_wb_en,
  input  logic [`AWIDTH-1:0] ib_i_wb_addr,
  input  logic [`DWIDTH-1:0] ib_i_wb_data,
  output logic               ib_o_valid,
  output logic [PKT_W-1:0]   ib_o_pkt,
  output logic               ib_o_full,
  output logic               ib_o_overflow
);

  localparam int AW      = `AWIDTH;
  localparam int DW      = `DWIDTH;
  // Operand field positions inside the packet (control bits occupy [6:0]).
  localparam int DRT_LSB = 7;
  localparam int DRS_LSB = DRT_LSB + DW;
  localparam int ARD_LSB = DRS_LSB + DW;
  localparam int ART_LSB = ARD_LSB + AW;
  localparam int ARS_LSB = ART_LSB + AW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } cnt_e;

  cnt_e             cnt_q, cnt_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             ovf_q, ovf_d;
  logic [PKT_W-1:0] mem_q [2];
  logic [PKT_W-1:0] mem_d [2];
  logic             pop_s, push_s, push_ok_s;
  logic             ent0_vld_s, ent1_vld_s;

  // Replace data_rs / data_rt with writeback data when the source address
  // matches; register 0 is hard-wired and never forwarded.
  function automatic logic [PKT_W-1:0] wb_patch(
    input logic [PKT_W-1:0] pkt,
    input logic             en,
    input logic [AW-1:0]    addr,
    input logic [DW-1:0]    data
  );
    logic [PKT_W-1:0] r;
    r = pkt;
    if (en && (addr != {AW{1'b0}})) begin
      if (pkt[ARS_LSB +: AW] == addr) r[DRS_LSB +: DW] = data;
      else                            r[DRS_LSB +: DW] = pkt[DRS_LSB +: DW];
      if (pkt[ART_LSB +: AW] == addr) r[DRT_LSB +: DW] = data;
      else                            r[DRT_LSB +: DW] = pkt[DRT_LSB +: DW];
    end else begin
      r = pkt;
    end
    return r;
  endfunction

  // Next-state computation: flush dominates, then push/pop/writeback patch.
  always_comb begin
    pop_s      = (cnt_q != EMPTY) & ib_i_ready;
    push_s     = ib_i_we & ~ib_i_flush;
    push_ok_s  = push_s & ((cnt_q != TWO) | pop_s);
    ent0_vld_s = (cnt_q == TWO) | ((cnt_q == ONE) & (rd_ptr_q == 1'b0));
    ent1_vld_s = (cnt_q == TWO) | ((cnt_q == ONE) & (rd_ptr_q == 1'b1));
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    mem_d[0]   = mem_q[0];
    mem_d[1]   = mem_q[1];
    if (ib_i_flush) begin
      cnt_d    = EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (ent0_vld_s) mem_d[0] = wb_patch(mem_q[0], ib_i_wb_en, ib_i_wb_addr, ib_i_wb_data);
      else            mem_d[0] = mem_q[0];
      if (ent1_vld_s) mem_d[1] = wb_patch(mem_q[1], ib_i_wb_en, ib_i_wb_addr, ib_i_wb_data);
      else            mem_d[1] = mem_q[1];
      // The incoming packet wins over any patch of the slot it overwrites.
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = wb_patch(ib_i_pkt, ib_i_wb_en, ib_i_wb_addr, ib_i_wb_data);
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) rd_ptr_d = ~rd_ptr_q;
      else       rd_ptr_d = rd_ptr_q;
      if (push_s && !push_ok_s) ovf_d = 1'b1;
      else                      ovf_d = ovf_q;
      case ({push_ok_s, pop_s})
        2'b10: begin
          case (cnt_q)
            EMPTY:   cnt_d = ONE;
            ONE:     cnt_d = TWO;
            default: cnt_d = TWO;
          endcase
        end
        2'b01: begin
          case (cnt_q)
            TWO:     cnt_d = ONE;
            ONE:     cnt_d = EMPTY;
            default: cnt_d = EMPTY;
          endcase
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with asynchronous clear of count, pointers, storage and flag.
  always_ff @(posedge ib_clk or posedge ib_rst) begin
    if (ib_rst) begin
      cnt_q    <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      ovf_q    <= 1'b0;
      mem_q[0] <= {PKT_W{1'b0}};
      mem_q[1] <= {PKT_W{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

  // Status decodes of registered state; the head reflects a same-cycle writeback.
  assign ib_o_valid    = (cnt_q != EMPTY);
  assign ib_o_full     = (cnt_q == TWO);
  assign ib_o_overflow = ovf_q;
  assign ib_o_pkt      = ib_o_valid ?
                         wb_patch(mem_q[rd_ptr_q], ib_i_wb_en, ib_i_wb_addr, ib_i_wb_data) :
                         mem_q[rd_ptr_q];

endmodule
